// File: rtl/stage_share_arbiter.sv
// Round-robin arbiter sharing one registered capture stage among N_REQ requesters,
// with optional bounded burst locking by the current winner.
module stage_share_arbiter #(
   parameter  int N_REQ     = 4,
   parameter  int WIDTH     = 1,
   parameter  int MAX_BURST = 4,
   localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW        = $clog2(MAX_BURST + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         lock,
   input  logic [N_REQ*WIDTH-1:0]   in_data,
   output logic [N_REQ-1:0]         grant,
   output logic [WIDTH-1:0]         out,
   output logic                     out_valid,
   output logic [IDW-1:0]           out_id,
   output logic                     busy
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t                         state_q, state_d;
   logic [IDW-1:0]                 ptr_q, ptr_d;
   logic [IDW-1:0]                 owner_q, owner_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [N_REQ-1:0]               grant_d;
   logic [WIDTH-1:0]               out_d;
   logic                           out_valid_d;
   logic [IDW-1:0]                 out_id_d;
   logic [N_REQ-1:0][WIDTH-1:0]    lane_data;

   logic                           rr_any;
   logic [IDW-1:0]                 rr_win;

   assign lane_data = in_data;
   assign busy      = (state_q == OWN);

   // Scan from highest offset down so the last hit is the one closest to ptr.
   always_comb begin
      int idx;
      idx    = 0;
      rr_any = 1'b0;
      rr_win = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr_q) + i) % N_REQ;
         if (req[IDW'(idx)]) begin
            rr_any = 1'b1;
            rr_win = IDW'(idx);
         end
      end
   end

   always_comb begin
      logic           do_cap;
      logic [IDW-1:0] sel;
      logic [CW-1:0]  cnt_inc;
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      out_d       = out;
      out_id_d    = out_id;
      out_valid_d = 1'b0;
      grant_d     = '0;
      do_cap      = 1'b0;
      sel         = '0;
      cnt_inc     = cnt_q + CW'(1);

      if (state_q == OWN && req[owner_q] && lock[owner_q]) begin
         do_cap = 1'b1;
         sel    = owner_q;
         cnt_d  = cnt_inc;
         if (cnt_inc == CW'(MAX_BURST)) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else begin
         // Releasing owner falls straight into normal arbitration: no dead cycle.
         if (state_q == OWN) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         if (rr_any) begin
            do_cap = 1'b1;
            sel    = rr_win;
            ptr_d  = (rr_win == IDW'(N_REQ - 1)) ? '0 : rr_win + IDW'(1);
            if (lock[rr_win] && (MAX_BURST > 1)) begin
               state_d = OWN;
               owner_d = rr_win;
               cnt_d   = CW'(1);
            end
         end
      end

      if (do_cap) begin
         grant_d[sel] = 1'b1;
         out_d        = lane_data[sel];
         out_id_d     = sel;
         out_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         grant     <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         out_id    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         grant     <= grant_d;
         out       <= out_d;
         out_valid <= out_valid_d;
         out_id    <= out_id_d;
      end
   end

endmodule

// File: tb/tb_stage_share_arbiter.sv
// Bench for stage_share_arbiter: directed scenarios plus random traffic, all
// checked against a behavioural round-robin/burst model.
module tb_stage_share_arbiter;
   localparam int N  = 4;
   localparam int W  = 4;
   localparam int MB = 4;
   localparam int IDW = 2;

   logic             clock = 1'b0;
   logic             reset;
   logic [N-1:0]     req, lock;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     grant;
   logic [W-1:0]     out;
   logic             out_valid;
   logic [IDW-1:0]   out_id;
   logic             busy;

   int total = 0;
   int bad   = 0;

   // model state and expected registered outputs
   int m_ptr, m_owner, m_cnt;
   bit m_own;
   int e_grant, e_out, e_valid, e_id;

   stage_share_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clock(clock), .reset(reset), .req(req), .lock(lock), .in_data(in_data),
      .grant(grant), .out(out), .out_valid(out_valid), .out_id(out_id), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic capture(input int w);
      e_grant = 1 << w;
      e_out   = int'(in_data[w*W +: W]);
      e_id    = w;
      e_valid = 1;
   endtask

   task automatic model_step();
      int w;
      if (!reset) begin
         m_ptr = 0; m_owner = 0; m_cnt = 0; m_own = 0;
         e_grant = 0; e_out = 0; e_valid = 0; e_id = 0;
         return;
      end
      e_grant = 0;
      e_valid = 0;
      if (m_own && req[m_owner] && lock[m_owner]) begin
         capture(m_owner);
         m_cnt++;
         if (m_cnt == MB) begin m_own = 0; m_cnt = 0; end
      end else begin
         if (m_own) begin m_own = 0; m_cnt = 0; end
         w = -1;
         for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) begin w = (m_ptr + k) % N; break; end
         end
         if (w >= 0) begin
            capture(w);
            m_ptr = (w + 1) % N;
            if (lock[w] && MB > 1) begin m_own = 1; m_owner = w; m_cnt = 1; end
         end
      end
   endtask

   // Inputs already set; model the edge, take it, then compare off-edge.
   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      chk("grant", int'(grant), e_grant);
      chk("out_valid", int'(out_valid), e_valid);
      chk("out", int'(out), e_out);
      chk("out_id", int'(out_id), e_id);
      chk("busy", int'(busy), int'(m_own));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; req = '0; lock = '0;
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k & 1);

      // reset with all requesting
      req = 4'b1111;
      cycle();
      cycle();
      chk("rst_grant", int'(grant), 0);
      chk("rst_valid", int'(out_valid), 0);
      reset = 1'b1;
      // round-robin sweep 0001,0010,0100,1000,0001
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("rr_grant", int'(grant), 1 << (i % 4));
         chk("rr_out", int'(out), (i % 4) & 1);
      end

      // sparse/wrap: drive ptr to 3 with a single grant of source 2
      req = 4'b0100; cycle();
      req = 4'b0101; cycle(); chk("wrap_g0", int'(grant), 4'b0001);
      cycle();                chk("wrap_g2", int'(grant), 4'b0100);
      cycle();                chk("wrap_g0b", int'(grant), 4'b0001);
      req = 4'b1000; cycle(); chk("wrap_g3", int'(grant), 4'b1000);
      req = 4'b0011; cycle(); chk("wrap_ptr0", int'(grant), 4'b0001);

      // full burst
      req = 4'b0000; do_reset();
      req = 4'b0011; lock = 4'b0001;
      for (int b = 1; b <= 4; b++) begin
         cycle();
         chk("burst_g", int'(grant), 4'b0001);
         chk("burst_busy", int'(busy), (b < 4) ? 1 : 0);
      end
      cycle(); chk("burst_next", int'(grant), 4'b0010);
      cycle(); chk("burst_back", int'(grant), 4'b0001);

      // early release after beat 2
      req = 4'b0000; lock = 4'b0000; do_reset();
      req = 4'b0011; lock = 4'b0001;
      cycle(); cycle();
      lock = 4'b0000;
      cycle();
      chk("early_g", int'(grant), 4'b0010);
      chk("early_busy", int'(busy), 0);

      // reset mid-burst
      req = 4'b0000; do_reset();
      req = 4'b0011; lock = 4'b0001;
      cycle(); cycle();
      reset = 1'b0; cycle();
      chk("mid_rst_g", int'(grant), 0);
      chk("mid_rst_busy", int'(busy), 0);
      reset = 1'b1; lock = 4'b0000;
      cycle();
      chk("mid_rst_restart", int'(grant), 4'b0001);

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         reset   = ($urandom_range(0, 99) != 0);
         req     = N'($urandom);
         lock    = ($urandom_range(0, 3) == 0) ? N'($urandom) : req & N'($urandom);
         in_data = (N*W)'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stage_share_arbiter.md
Name: stage_share_arbiter

Overview:
Round-robin arbiter that shares one registered capture stage among N_REQ requesters. Each cycle it picks one requesting source, captures that source's data into the shared output register, and returns a registered one-hot grant as the acknowledge. Requesters can lock the stage for bounded bursts. It sits in front of the chained register stages and feeds their single input, so several producers can use one delay pipeline.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 1, data width per requester
MAX_BURST, 4, max consecutive beats one locked owner may hold the stage (>=1; 1 disables locking)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
req  input  N_REQ  per-requester request, level
lock  input  N_REQ  per-requester burst-hold request, sampled only with req
in_data  input  N_REQ*WIDTH  requester k data at bits [k*WIDTH +: WIDTH]
grant  output  N_REQ  registered one-hot acknowledge; bit k high = k's data captured at the previous edge
out  output  WIDTH  shared stage register
out_valid  output  1  out updated at the previous edge
out_id  output  clog2(N_REQ) (min 1)  index of source of out
busy  output  1  high while in OWN state

Behaviour:
- Reset: one clock and a synchronous, active-low reset; the reset input is sampled low at a rising edge of clock. It overrides everything. On reset: grant=0, out=0, out_valid=0, out_id=0, internal ptr=0, beat count=0, state=IDLE.
- Internal state: ptr (rotating priority start), owner index, beat count (0..MAX_BURST), FSM {IDLE, OWN}.
- Winner selection in IDLE: the first k with req[k]=1, searching ptr, ptr+1, ... with wrap mod N_REQ.
- IDLE, any req set, at the edge:
  - grant <= onehot(winner), out <= in_data[winner], out_id <= winner, out_valid <= 1.
  - ptr <= (winner+1) mod N_REQ.
  - If lock[winner]=1 and MAX_BURST>1: state <= OWN, owner <= winner, count <= 1.
- IDLE, no req: grant <= 0, out_valid <= 0. out and out_id hold their values.
- OWN, req[owner]=1 and lock[owner]=1:
  - The owner wins regardless of other requests: capture as above, count <= count+1.
  - When the new count equals MAX_BURST: state <= IDLE, count <= 0.
  - ptr stays at owner+1.
- OWN, req[owner]=0 or lock[owner]=0:
  - state <= IDLE, count <= 0.
  - In the same cycle, normal round-robin arbitration runs from ptr (owner+1), so there is no dead cycle. The owner is eligible only if req[owner]=1 and no other requester is found first.
- Latency: data presented in cycle t appears on out in cycle t+1 with grant bit, out_valid and out_id aligned.
- A requester keeps req and in_data stable until it sees its grant bit, and drops req or moves to the next datum the cycle after.
- Fairness: with lock deasserted everywhere, each continuously requesting source is granted at least once every N_REQ cycles. With locking, the bound is N_REQ*MAX_BURST cycles.
- busy=1 exactly when state=OWN.
- Wrap: a winner at N_REQ-1 sets ptr=0.
- lock without req is ignored.
- grant is never multi-hot and is never set without out_valid.

Test Plan:
- Reset: drive reset=0 for 2 cycles with req=4'b1111 -> grant=0, out_valid=0, out=0, out_id=0; release -> first grant=4'b0001 at the next edge.
- Round-robin: req=4'b1111 held, lock=0, in_data k = k&1 -> grant sequence 0001,0010,0100,1000,0001; out_id 0,1,2,3,0; out 0,1,0,1.
- Sparse/wrap: ptr=3 state, req=4'b0101 -> grant 0001 then 0100 then 0001; a single req=4'b1000 -> grant 1000, next ptr=0.
- Burst: MAX_BURST=4, req=4'b0011, lock=4'b0001 -> grant 0001 four consecutive cycles with busy=1 on beats 1-3, then 0010, then 0001.
- Early release: in the same setup, lock[0] drops after beat 2 -> beat 3 grant=0010 with no idle cycle; busy falls together with it.
- Reset mid-burst: assert reset=0 during OWN beat 2 -> next edge gives grant=0, busy=0, out_valid=0; after release, arbitration restarts from ptr=0.
